// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width, access-size encodings and FSM state type for the LSU
package lsu_pkg;

    localparam int XLEN = 64;

    // Access size encodings as carried on in_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane alignment for LSU requests and load returns
// Request side: req_off/req_size/req_wdata -> req_mask, req_wdata_sh, req_misalign.
// Response side: rsp_off/rsp_size/rsp_unsigned/rsp_rdata -> rsp_data (shifted, truncated, extended).
module lsu_align #(
    parameter int XLEN = 64
) (
    input  logic [2:0]      req_off,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,
    output logic [7:0]      req_mask,
    output logic [XLEN-1:0] req_wdata_sh,
    output logic            req_misalign,
    input  logic [2:0]      rsp_off,
    input  logic [1:0]      rsp_size,
    input  logic            rsp_unsigned,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0] rsp_data
);
    import lsu_pkg::*;

    logic [7:0]      base_mask;
    logic [XLEN-1:0] rsp_sh;

    always_comb begin
        base_mask    = 8'hFF;
        req_misalign = 1'b0;
        case (req_size)
            SZ_B: begin
                base_mask = 8'h01;
            end
            SZ_H: begin
                base_mask    = 8'h03;
                req_misalign = req_off[0];
            end
            SZ_W: begin
                base_mask    = 8'h0F;
                req_misalign = |req_off[1:0];
            end
            default: begin
                base_mask    = 8'hFF;
                req_misalign = |req_off;
            end
        endcase
    end

    // Lanes shifted past bit 7 (or past XLEN for data) fall off; only aligned requests reach memory.
    assign req_mask     = base_mask << req_off;
    assign req_wdata_sh = req_wdata << {req_off, 3'b000};

    assign rsp_sh = rsp_rdata >> {rsp_off, 3'b000};

    always_comb begin
        rsp_data = rsp_sh;
        case (rsp_size)
            SZ_B:    rsp_data = {{(XLEN-8){~rsp_unsigned & rsp_sh[7]}}, rsp_sh[7:0]};
            SZ_H:    rsp_data = {{(XLEN-16){~rsp_unsigned & rsp_sh[15]}}, rsp_sh[15:0]};
            SZ_W:    rsp_data = {{(XLEN-32){~rsp_unsigned & rsp_sh[31]}}, rsp_sh[31:0]};
            default: rsp_data = rsp_sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit between EXU, WBU and a fixed-latency memory
// clk/rst: single clock, synchronous active-high reset.
// in_*: request from EXU (valid/ready), out_*: response to WBU (valid/ready).
// mem_*: doubleword-aligned memory port; mem_rdata is sampled MEM_LATENCY cycles after drive.
module lsu #(
    parameter int XLEN        = lsu_pkg::XLEN,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_wen,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic [4:0]      out_rd,
    output logic            out_misalign,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_raddr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_mask
);
    import lsu_pkg::*;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic            wen_q;
    logic [7:0]      mask_q;
    logic [XLEN-1:0] wdata_q;
    logic            accept;
    logic [7:0]      req_mask;
    logic [XLEN-1:0] req_wdata_sh;
    logic            req_misalign;
    logic [XLEN-1:0] load_data;

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_off      (in_addr[2:0]),
        .req_size     (in_size),
        .req_wdata    (in_wdata),
        .req_mask     (req_mask),
        .req_wdata_sh (req_wdata_sh),
        .req_misalign (req_misalign),
        .rsp_off      (addr_q[2:0]),
        .rsp_size     (size_q),
        .rsp_unsigned (unsigned_q),
        .rsp_rdata    (mem_rdata),
        .rsp_data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_wen   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    state_nxt = req_misalign ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Counter is loaded with LAT on entry, so this marks the first WAIT cycle.
                mem_wen = wen_q && (cnt == LAT);
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // A response caught by reset is abandoned, so never present it during reset.
                out_valid = ~rst;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            addr_q       <= '0;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            wen_q        <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
            out_rdata    <= '0;
            out_rd       <= '0;
            out_misalign <= 1'b0;
        end else if (accept) begin
            addr_q       <= in_addr;
            size_q       <= in_size;
            unsigned_q   <= in_unsigned;
            wen_q        <= in_wen;
            mask_q       <= req_mask;
            wdata_q      <= req_wdata_sh;
            cnt          <= req_misalign ? 4'd0 : LAT;
            out_rd       <= in_rd;
            out_rdata    <= '0;
            out_misalign <= req_misalign;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && !wen_q) begin
                out_rdata <= load_data;
            end
        end
    end

    assign mem_raddr = {addr_q[XLEN-1:3], 3'b000};
    assign mem_waddr = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wdata = wdata_q;
    assign mem_mask  = mask_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with MEM_LATENCY 1 and 3 instances
module tb_lsu;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        e_mis;
        logic [63:0] e_rdata;
        logic [7:0]  e_mask;
        logic [63:0] e_mwdata;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_wen, in_unsigned, out_ready;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata, mem_rdata;
    logic [4:0]  in_rd;
    logic        in_ready, out_valid, out_misalign, mem_wen;
    logic [63:0] out_rdata, mem_raddr, mem_waddr, mem_wdata;
    logic [4:0]  out_rd;
    logic [7:0]  mem_mask;

    logic        rst3, in_valid3, in_wen3, in_unsigned3, out_ready3;
    logic [1:0]  in_size3;
    logic [63:0] in_addr3, in_wdata3, mem_rdata3;
    logic [4:0]  in_rd3;
    logic        in_ready3, out_valid3, out_misalign3, mem_wen3;
    logic [63:0] out_rdata3, mem_raddr3, mem_waddr3, mem_wdata3;
    logic [4:0]  out_rd3;
    logic [7:0]  mem_mask3;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[14];
    vec_t hold_v;

    always #5 clk = ~clk;

    lsu #(.XLEN(64), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_misalign(out_misalign), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_mask(mem_mask)
    );

    lsu #(.XLEN(64), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3), .in_wen(in_wen3),
        .in_size(in_size3), .in_unsigned(in_unsigned3), .in_addr(in_addr3), .in_wdata(in_wdata3),
        .in_rd(in_rd3), .out_valid(out_valid3), .out_ready(out_ready3), .out_rdata(out_rdata3),
        .out_rd(out_rd3), .out_misalign(out_misalign3), .mem_wen(mem_wen3), .mem_raddr(mem_raddr3),
        .mem_rdata(mem_rdata3), .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3), .mem_mask(mem_mask3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every handshake on the latency-1 instance must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_response: got out_valid=1 rd=%0d required no response", out_rd);
            end else begin
                mon_e = sb.pop_front();
                check("out_rdata", out_rdata, mon_e.rdata);
                check("out_rd", 64'(out_rd), 64'(mon_e.rd));
                check("out_misalign", 64'(out_misalign), 64'(mon_e.mis));
            end
        end
    end

    task automatic run_vec(input vec_t v, input int hold);
        exp_t        e;
        int          lat;
        int          wen_cnt;
        logic [63:0] base;
        base    = {v.addr[63:3], 3'b000};
        e.rdata = v.e_rdata;
        e.rd    = v.rd;
        e.mis   = v.e_mis;
        sb.push_back(e);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_wen      = v.wen;
        in_size     = v.size;
        in_unsigned = v.uns;
        in_addr     = v.addr;
        in_wdata    = v.wdata;
        in_rd       = v.rd;
        mem_rdata   = v.rdata;
        out_ready   = (hold == 0);
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        wen_cnt  = 0;
        check("mem_raddr", mem_raddr, base);
        check("mem_waddr", mem_waddr, base);
        while (!out_valid && lat < 40) begin
            if (mem_wen) begin
                wen_cnt++;
                check("mem_mask", 64'(mem_mask), 64'(v.e_mask));
                check("mem_wdata", mem_wdata, v.e_mwdata);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), v.e_mis ? 64'd1 : 64'd2);
        check("wen_count", 64'(wen_cnt), (v.wen && !v.e_mis) ? 64'd1 : 64'd0);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_rdata", out_rdata, v.e_rdata);
            check("hold_rd", 64'(out_rd), 64'(v.rd));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_wen", 64'(mem_wen), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("back_idle", 64'(in_ready), 64'd1);
        check("back_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int wen_cnt;
        //            wen   size  uns   addr                   wdata                  rd     rdata                  mis   e_rdata                e_mask e_mwdata
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0003, 64'h0,                 5'd1,  64'h0000_0000_8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 64'h0000_0000_8000_0006, 64'h1234,              5'd2,  64'h0,                 1'b0, 64'h0,                 8'hC0, 64'h1234_0000_0000_0000};
        vecs[2]  = '{1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0002, 64'h0,                 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0,                 8'h00, 64'h0};
        vecs[3]  = '{1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_0004, 64'h0,                 5'd4,  64'hDEAD_BEEF_0000_0000, 1'b0, 64'h0000_0000_DEAD_BEEF, 8'h00, 64'h0};
        vecs[4]  = '{1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0008, 64'h0,                 5'd5,  64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 64'h0000_0000_8000_0002, 64'h0,                 5'd6,  64'h0000_0000_8001_0000, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 64'h0000_0000_8000_0002, 64'h0,                 5'd7,  64'h0000_0000_8001_0000, 1'b0, 64'h0000_0000_0000_8001, 8'h00, 64'h0};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 64'h0000_0000_8000_0007, 64'h0,                 5'd8,  64'hAB00_0000_0000_0000, 1'b0, 64'h0000_0000_0000_00AB, 8'h00, 64'h0};
        vecs[8]  = '{1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0004, 64'hFFFF_0000_FFFF_0000, 5'd10, 64'h0,                 1'b1, 64'h0,                 8'h00, 64'h0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 64'h0000_0000_8000_0004, 64'hFFFF_FFFF_CAFE_BABE, 5'd11, 64'h0,                 1'b0, 64'h0,                 8'hF0, 64'hCAFE_BABE_0000_0000};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 64'h0000_0000_8000_0001, 64'h5A,                5'd12, 64'h0,                 1'b0, 64'h0,                 8'h02, 64'h0000_0000_0000_5A00};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0000, 64'h0,                 5'd13, 64'h1234_5678_FFFF_FFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 8'h00, 64'h0};
        vecs[12] = '{1'b0, 2'd1, 1'b0, 64'h0000_0000_8000_0001, 64'h0,                 5'd14, 64'h0,                 1'b1, 64'h0,                 8'h00, 64'h0};
        vecs[13] = '{1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 5'd15, 64'h0,                 1'b0, 64'h0,                 8'hFF, 64'h1122_3344_5566_7788};
        hold_v   = '{1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0018, 64'h0,                 5'd9,  64'h5555_AAAA_3333_CCCC, 1'b0, 64'h5555_AAAA_3333_CCCC, 8'h00, 64'h0};

        rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
        in_addr = '0; in_wdata = '0; in_rd = '0; out_ready = 1'b1; mem_rdata = '0;
        rst3 = 1'b1; in_valid3 = 1'b0; in_wen3 = 1'b0; in_size3 = 2'd0; in_unsigned3 = 1'b0;
        in_addr3 = '0; in_wdata3 = '0; in_rd3 = '0; out_ready3 = 1'b1; mem_rdata3 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_mem_raddr", mem_raddr, 64'd0);
        check("rst_mem_waddr", mem_waddr, 64'd0);
        check("rst_out_rdata", out_rdata, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_misalign", 64'(out_misalign), 64'd0);
        check("rst3_in_ready", 64'(in_ready3), 64'd0);
        rst = 1'b0;
        rst3 = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], 0);
        end

        // Stalled response: WBU withholds out_ready for five cycles.
        run_vec(hold_v, 5);

        // Reset while a load sits in RESP: the response must vanish.
        out_ready = 1'b0;
        in_wen = 1'b0; in_size = 2'd3; in_addr = 64'h8000_0000; in_rd = 5'd21; mem_rdata = 64'h77;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("resp_before_rst", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("resp_rst_valid", 64'(out_valid), 64'd0);
        check("resp_rst_rd", 64'(out_rd), 64'd0);
        check("resp_rst_rdata", out_rdata, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("resp_rst_idle", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("resp_rst_no_valid", 64'(out_valid), 64'd0);

        // Latency-3 instance: aligned doubleword load.
        in_wen3 = 1'b0; in_size3 = 2'd3; in_unsigned3 = 1'b0; in_addr3 = 64'h8000_0020;
        in_rd3 = 5'd7; mem_rdata3 = 64'hA5A5_5A5A_0F0F_F0F0;
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat = 1;
        while (!out_valid3 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat3_load_latency", 64'(lat), 64'd4);
        check("lat3_out_rdata", out_rdata3, 64'hA5A5_5A5A_0F0F_F0F0);
        check("lat3_out_rd", 64'(out_rd3), 64'd7);
        check("lat3_out_misalign", 64'(out_misalign3), 64'd0);
        check("lat3_mem_raddr", mem_raddr3, 64'h8000_0020);
        @(posedge clk); #1;
        check("lat3_back_idle", 64'(in_ready3), 64'd1);

        // Latency-3 store interrupted by reset in its second WAIT cycle.
        in_wen3 = 1'b1; in_size3 = 2'd3; in_addr3 = 64'h8000_0028;
        in_wdata3 = 64'h0102_0304_0506_0708; in_rd3 = 5'd4;
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        wen_cnt = mem_wen3 ? 1 : 0;
        check("sd3_wen_first", 64'(mem_wen3), 64'd1);
        check("sd3_waddr", mem_waddr3, 64'h8000_0028);
        check("sd3_mask", 64'(mem_mask3), 64'hFF);
        check("sd3_wdata", mem_wdata3, 64'h0102_0304_0506_0708);
        @(posedge clk); #1;
        if (mem_wen3) wen_cnt++;
        rst3 = 1'b1;
        @(posedge clk); #1;
        check("sd3_rst_valid", 64'(out_valid3), 64'd0);
        check("sd3_rst_in_ready", 64'(in_ready3), 64'd0);
        rst3 = 1'b0;
        #1;
        check("sd3_idle_after_rst", 64'(in_ready3), 64'd1);
        for (int i = 0; i < 6; i++) begin
            if (mem_wen3) wen_cnt++;
            check("sd3_no_valid", 64'(out_valid3), 64'd0);
            @(posedge clk); #1;
        end
        check("sd3_wen_total", 64'(wen_cnt), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t required completion", $time);
        $fatal(1, "bench timeout");
    end

endmodule
